// File: rtl/lbp_stream.sv
`default_nettype none
// ============================================================================
// lbp_stream : streaming 3x3 Local Binary Pattern engine with a 3-row ring
//              buffer. Define LBP_THRESH_EN to add the lbp_thresh input.
// Rev 1.0
// ============================================================================
module lbp_stream #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] gray_addr,
  output logic          gray_req,
  input  logic          gray_ready,
  input  logic [DW-1:0] gray_data,
  output logic [AW-1:0] lbp_addr,
  output logic          lbp_valid,
  input  logic          lbp_ready,
  output logic [7:0]    lbp_data,
  output logic          busy,
  output logic          finish
`ifdef LBP_THRESH_EN
  ,
  input  logic [DW-1:0] lbp_thresh
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   crow_q;
  logic [1:0]      ld_slot_q;
  logic [1:0]      c_slot_q;
  logic [AW-1:0]   rd_addr_q;
  logic [AW-1:0]   wr_addr_q;
  logic            arm_q;
  logic [DW-1:0]   ring_q [3][IMG_W];
  logic [DW-1:0]   thr_w;

  logic [CW-1:0]   xm, xp;
  logic [1:0]      us, ds;
  logic [DW:0]     cmp_ref;
  logic [DW-1:0]   nb [8];
  logic            interior;
  logic [7:0]      code;

  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] slot_dec(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

`ifdef LBP_THRESH_EN
  logic [DW-1:0] thr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      thr_q <= lbp_thresh;
    end
  end
  assign thr_w = thr_q;
`else
  assign thr_w = '0;
`endif

  // 3x3 window around (crow_q, col_q); edge columns are clamped, the result is masked anyway
  always_comb begin
    xm       = (col_q == '0) ? col_q : col_q - CW'(1);
    xp       = (col_q == COL_LAST) ? col_q : col_q + CW'(1);
    us       = slot_dec(c_slot_q);
    ds       = slot_inc(c_slot_q);
    cmp_ref  = {1'b0, ring_q[c_slot_q][col_q]} + {1'b0, thr_w};
    nb[0]    = ring_q[us][xm];
    nb[1]    = ring_q[us][col_q];
    nb[2]    = ring_q[us][xp];
    nb[3]    = ring_q[c_slot_q][xm];
    nb[4]    = ring_q[c_slot_q][xp];
    nb[5]    = ring_q[ds][xm];
    nb[6]    = ring_q[ds][col_q];
    nb[7]    = ring_q[ds][xp];
    interior = (crow_q != '0) && (crow_q != ROW_LAST) &&
               (col_q != '0) && (col_q != COL_LAST);
    code     = '0;
    for (int k = 0; k < 8; k++) begin
      code[k] = ({1'b0, nb[k]} >= cmp_ref);
    end
    if (!interior) begin
      code = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    gray_req  = 1'b0;
    gray_addr = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = '0;
    busy      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        gray_req  = 1'b1;
        gray_addr = rd_addr_q;
        if (gray_ready && col_q == COL_LAST && row_q != '0) state_d = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        // arm_q inserts the idle cycle that separates consecutive rows
        if (arm_q) begin
          lbp_valid = 1'b1;
          lbp_addr  = wr_addr_q;
          lbp_data  = code;
          if (lbp_ready && col_q == COL_LAST) begin
            if (crow_q == ROW_LAST)     state_d = S_DONE;
            else if (row_q == ROW_LAST) state_d = S_CALC;
            else                        state_d = S_LOAD;
          end
        end
      end
      default: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      crow_q    <= '0;
      ld_slot_q <= '0;
      c_slot_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      arm_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            col_q     <= '0;
            row_q     <= '0;
            crow_q    <= '0;
            ld_slot_q <= '0;
            c_slot_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            arm_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (gray_ready) begin
            rd_addr_q <= rd_addr_q + AW'(1);
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == '0) begin
                row_q     <= RW'(1);
                ld_slot_q <= 2'd1;
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_CALC: begin
          if (!arm_q) arm_q <= 1'b1;
          if (lbp_valid && lbp_ready) begin
            wr_addr_q <= wr_addr_q + AW'(1);
            if (col_q == COL_LAST) begin
              col_q <= '0;
              arm_q <= 1'b0;
              if (crow_q != ROW_LAST) begin
                crow_q   <= crow_q + RW'(1);
                c_slot_q <= slot_inc(c_slot_q);
              end
              if (row_q != ROW_LAST) begin
                row_q     <= row_q + RW'(1);
                ld_slot_q <= slot_inc(ld_slot_q);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == S_LOAD && gray_ready) begin
      ring_q[ld_slot_q][col_q] <= gray_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lbp_stream.sv
`default_nettype none
// ============================================================================
// tb_lbp_stream : randomized self-checking bench for lbp_stream (4x4 image)
// Rev 1.0
// ============================================================================
module tb_lbp_stream;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset, start, gray_ready, lbp_ready;
  logic [AW-1:0] gray_addr, lbp_addr;
  logic          gray_req, lbp_valid, busy, finish;
  logic [7:0]    gray_data, lbp_data;

  logic [7:0]    img [NPIX];
  int            exp_code [NPIX];
  int            thr_v;

  int n_total, n_bad;
  int gmode, lmode;
  bit mon_en;
  int rd_cnt, wr_cnt, fin_cnt;
  bit g_stall, l_stall, row_end;
  logic [AW-1:0] g_addr_h, l_addr_h;
  logic [7:0]    l_data_h;

  initial forever #5 clk = ~clk;

  assign gray_data = img[gray_addr];

`ifdef LBP_THRESH_EN
  logic [7:0] thr_port;
  assign thr_port = thr_v[7:0];
`endif

  lbp_stream #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(AW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .lbp_addr   (lbp_addr),
    .lbp_valid  (lbp_valid),
    .lbp_ready  (lbp_ready),
    .lbp_data   (lbp_data),
    .busy       (busy),
    .finish     (finish)
`ifdef LBP_THRESH_EN
    ,
    .lbp_thresh (thr_port)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: neighbour order is (-1,-1) (-1,0) (-1,1) (0,-1) (0,1) (1,-1) (1,0) (1,1)
  function automatic void build_exp();
    int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int c, code;
        code = 0;
        if (y > 0 && y < H - 1 && x > 0 && x < W - 1) begin
          c = int'(img[y * W + x]);
          for (int k = 0; k < 8; k++) begin
            if (int'(img[(y + dy[k]) * W + x + dx[k]]) >= c + thr_v) code += (1 << k);
          end
        end
        exp_code[y * W + x] = code;
      end
    end
  endfunction

  task automatic fill_img(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       img[i] = 8'h55;
        1:       img[i] = 8'(i);
        2:       img[i] = 8'($urandom_range(0, 255));
        3:       img[i] = 8'($urandom_range(0, 3));
        default: img[i] = 8'hFF;
      endcase
    end
  endtask

  task automatic mon_clear();
    rd_cnt  = 0;
    wr_cnt  = 0;
    fin_cnt = 0;
    g_stall = 1'b0;
    l_stall = 1'b0;
    row_end = 1'b0;
  endtask

  // Ready drivers on the falling edge, protocol monitor just before the rising edge
  initial begin
    forever begin
      @(negedge clk);
      case (gmode)
        0:       gray_ready = 1'b1;
        1:       gray_ready = ~gray_ready;
        default: gray_ready = 1'($urandom_range(0, 1));
      endcase
      case (lmode)
        0:       lbp_ready = 1'b1;
        1:       lbp_ready = ~lbp_ready;
        default: lbp_ready = 1'($urandom_range(0, 1));
      endcase
      #3;
      if (mon_en) begin
        bit end_now;
        end_now = 1'b0;
        if (g_stall) begin
          chk("greq_hold", gray_req, 1'b1);
          chk("gaddr_hold", gray_addr, g_addr_h);
        end
        if (l_stall) begin
          chk("lvalid_hold", lbp_valid, 1'b1);
          chk("laddr_hold", lbp_addr, l_addr_h);
          chk("ldata_hold", lbp_data, l_data_h);
        end
        if (row_end) chk("row_gap", lbp_valid, 1'b0);
        if (lbp_valid) chk("req_in_calc", gray_req, 1'b0);
        if (gray_req || lbp_valid) chk("busy_active", busy, 1'b1);
        if (gray_req && gray_ready) begin
          chk("raddr", gray_addr, rd_cnt);
          rd_cnt++;
        end
        if (lbp_valid && lbp_ready) begin
          chk("waddr", lbp_addr, wr_cnt);
          if (wr_cnt < NPIX) chk("code", lbp_data, exp_code[wr_cnt]);
          end_now = ((wr_cnt % W) == W - 1);
          wr_cnt++;
        end
        if (finish) begin
          chk("fin_after_last", wr_cnt, NPIX);
          fin_cnt++;
        end
        row_end  = end_now;
        g_stall  = gray_req && !gray_ready;
        g_addr_h = gray_addr;
        l_stall  = lbp_valid && !lbp_ready;
        l_addr_h = lbp_addr;
        l_data_h = lbp_data;
      end
    end
  end

  task automatic run_frame(input int gm, input int lm, input bit extra);
    int  cyc;
    bit  fs;
    build_exp();
    gmode = gm;
    lmode = lm;
    mon_clear();
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    fs  = 1'b0;
    while (fin_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (extra && (cyc == 7 || cyc == 30)) start = 1'b1;
      if (extra && !fs && wr_cnt == NPIX) begin
        start = 1'b1;
        fs    = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    chk("frame_done", fin_cnt > 0, 1'b1);
    chk("rd_beats", rd_cnt, NPIX);
    chk("wr_beats", wr_cnt, NPIX);
    chk("fin_once", fin_cnt, 1);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_greq"}, gray_req, 1'b0);
    chk({tag, "_gaddr"}, gray_addr, '0);
    chk({tag, "_lvalid"}, lbp_valid, 1'b0);
    chk({tag, "_laddr"}, lbp_addr, '0);
    chk({tag, "_ldata"}, lbp_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_finish"}, finish, 1'b0);
  endtask

  task automatic reset_mid_frame();
    int cyc;
    bit seen;
    fill_img(2);
    build_exp();
    gmode = 2;
    lmode = 2;
    mon_clear();
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (wr_cnt < W + 1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_row1", wr_cnt >= W + 1, 1'b1);
    @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      #3;
      if (gray_req || lbp_valid || busy) seen = 1'b1;
    end
    chk("quiet_after_rst", seen, 1'b0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    gray_ready = 1'b1;
    lbp_ready  = 1'b1;
    gmode      = 0;
    lmode      = 0;
    mon_en     = 1'b0;
    thr_v      = 0;
    fill_img(0);
    repeat (3) @(negedge clk);
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    fill_img(0);
    run_frame(0, 0, 1'b0);
    fill_img(1);
    run_frame(0, 0, 1'b0);
    run_frame(1, 2, 1'b0);

    reset_mid_frame();
    fill_img(3);
    run_frame(2, 2, 1'b0);

    fill_img(2);
    run_frame(2, 2, 1'b1);

    for (int i = 0; i < 14; i++) begin
      fill_img((i % 2 == 0) ? 2 : 3);
`ifdef LBP_THRESH_EN
      thr_v = (i % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 2);
`endif
      run_frame($urandom_range(0, 2), $urandom_range(0, 2), (i % 4 == 0));
    end

`ifdef LBP_THRESH_EN
    thr_v = 1;
    fill_img(0);
    run_frame(0, 0, 1'b0);
    fill_img(4);
    run_frame(2, 2, 1'b0);
    thr_v = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
